// File: rtl/fnv_1a_stream.sv
// Streaming FNV-1a hash engine: multi-byte input beats, one octet hashed per cycle.
// Optional FNV_STREAM_MODE_EN adds a per-message `mode` input selecting FNV-1 instead of FNV-1a.
module fnv_1a_stream #(
  parameter int unsigned HASH_WIDTH = 32,
  parameter int unsigned IN_BYTES   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [8*IN_BYTES-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [$clog2(IN_BYTES):0]   in_nbytes,
`ifdef FNV_STREAM_MODE_EN
  input  logic                        mode,
`endif
  output logic                        in_ready,
  output logic [HASH_WIDTH-1:0]       hash_out,
  output logic                        hash_valid,
  input  logic                        hash_ready
);

  if (!(HASH_WIDTH == 32 || HASH_WIDTH == 64)) begin : g_bad_width
    $fatal(1, "fnv_1a_stream: HASH_WIDTH must be 32 or 64");
  end
  if (IN_BYTES < 1 || IN_BYTES > 4) begin : g_bad_bytes
    $fatal(1, "fnv_1a_stream: IN_BYTES must be in 1..4");
  end

  localparam int unsigned NBW = $clog2(IN_BYTES) + 1;
  localparam logic [NBW-1:0] INB = NBW'(IN_BYTES);
  localparam logic [63:0] BASIS_SEL = (HASH_WIDTH == 64) ? 64'hCBF2_9CE4_8422_2325
                                                         : 64'h0000_0000_811C_9DC5;
  localparam logic [63:0] PRIME_SEL = (HASH_WIDTH == 64) ? 64'h0000_0100_0000_01B3
                                                         : 64'h0000_0000_0100_0193;
  localparam logic [HASH_WIDTH-1:0] BASIS = BASIS_SEL[HASH_WIDTH-1:0];
  localparam logic [HASH_WIDTH-1:0] PRIME = PRIME_SEL[HASH_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [HASH_WIDTH-1:0]   h;
  logic [8*IN_BYTES-1:0]   shreg;
  logic [NBW-1:0]          cnt;
  logic                    last_q;
  logic                    accept;
  logic [NBW-1:0]          n;
  logic                    mode_acc;
  logic                    mode_sh;
  logic [HASH_WIDTH-1:0]   h_beat0;
  logic [HASH_WIDTH-1:0]   h_shift;

  function automatic logic [HASH_WIDTH-1:0] step(input logic [HASH_WIDTH-1:0] hv,
                                                 input logic [7:0] b,
                                                 input logic m);
    logic [HASH_WIDTH-1:0] bx;
    bx = {{(HASH_WIDTH-8){1'b0}}, b};
    if (m) return (hv * PRIME) ^ bx;
    else   return (hv ^ bx) * PRIME;
  endfunction

`ifdef FNV_STREAM_MODE_EN
  logic mode_q;
  logic in_msg;

  // The first beat of a message uses the live input; later beats and SHIFT bytes use the latched copy.
  assign mode_acc = in_msg ? mode_q : mode;
  assign mode_sh  = mode_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      in_msg <= 1'b0;
    end else if (accept) begin
      if (!in_msg) mode_q <= mode;
      in_msg <= !in_last;
    end
  end
`else
  assign mode_acc = 1'b0;
  assign mode_sh  = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign hash_out = h;
  assign h_beat0  = step(h, in_data[7:0], mode_acc);
  assign h_shift  = step(h, shreg[7:0], mode_sh);

  always_comb begin
    n = INB;
    if (in_last && (in_nbytes < INB)) n = in_nbytes;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      h          <= BASIS;
      shreg      <= '0;
      cnt        <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b1;
      hash_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (n != '0) h <= h_beat0;
            shreg  <= in_data >> 8;
            cnt    <= (n != '0) ? n - 1'b1 : '0;
            last_q <= in_last;
            if (n > NBW'(1)) begin
              state    <= SHIFT;
              in_ready <= 1'b0;
            end else if (in_last) begin
              state      <= DONE;
              in_ready   <= 1'b0;
              hash_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          h     <= h_shift;
          shreg <= shreg >> 8;
          cnt   <= cnt - 1'b1;
          if (cnt == NBW'(1)) begin
            if (last_q) begin
              state      <= DONE;
              hash_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          if (hash_ready) begin
            h          <= BASIS;
            state      <= IDLE;
            in_ready   <= 1'b1;
            hash_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          hash_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fnv_1a_stream.md
# fnv_1a_stream

Parametrised streaming FNV-1a hash engine, successor to the fixed 32-bit hasher. It accepts a byte message as multi-byte beats on a valid/ready interface with a last-beat marker and a byte count. It hashes strictly one octet per cycle, as the FNV-1a algorithm defines. The finished digest is presented on a held valid/ready output. It sits between the I2C peripheral's receive buffer and the register file, and provides message checksums of 32 or 64 bits.

## Interface
- HASH_WIDTH, 32, digest width; legal values 32 or 64 only; any other value is a fatal elaboration error.
- IN_BYTES, 1, bytes per input beat; legal range 1..4.
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- in_data  input  8*IN_BYTES  beat data; byte k is in_data[8k+7:8k], and byte 0 is hashed first.
- in_valid  input  1  beat valid.
- in_last  input  1  beat is the final beat of the message.
- in_nbytes  input  $clog2(IN_BYTES)+1  valid byte count of the beat; used only when in_last=1.
- in_ready  output  1  engine can accept a beat.
- hash_out  output  HASH_WIDTH  digest.
- hash_valid  output  1  digest complete.
- hash_ready  input  1  consumer accepts the digest.

## Operation
- Constants for 32 bits: offset basis 0x811C9DC5, prime 0x01000193.
- Constants for 64 bits: offset basis 0xCBF29CE484222325, prime 0x00000100000001B3.
- Per byte b: h = (h ^ zero-extended b) * PRIME, truncated modulo 2^HASH_WIDTH.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready the beat is accepted.
  - Byte count n = IN_BYTES when in_last=0; otherwise n = min(in_nbytes, IN_BYTES).
  - Byte 0 is hashed in the accept cycle when n≥1.
  - The remaining bytes are latched in a shift register, and the remaining count n-1 is loaded.
  - Next state:
    - SHIFT if n-1>0.
    - DONE if in_last and n-1≤0.
    - Otherwise IDLE.
- SHIFT:
  - in_ready=0; one byte is hashed per cycle.
  - When the count reaches zero: DONE if the latched last flag is set, else IDLE.
- DONE:
  - hash_valid=1; in_ready=0; hash_out is held stable.
  - On hash_ready: h reloads to the offset basis and the FSM goes to IDLE.
- Zero-length message: an in_last beat with in_nbytes=0 hashes no bytes, so the digest is the offset basis.
- in_data, in_last and in_nbytes are ignored when no handshake occurs.
- Reset:
  - Any state goes to IDLE, with h = offset basis, hash_valid=0, in_ready=1.
  - A partial message is discarded.

## Timing
- Reset values: in_ready=1, hash_valid=0, hash_out=offset basis.
- A beat carrying n≥1 bytes occupies exactly n cycles: the accept cycle plus n-1 SHIFT cycles.
- IN_BYTES=1 gives full throughput of one byte per cycle with in_ready held high.
- hash_valid rises the cycle after the final byte is hashed. The same applies after accepting a zero-byte last beat.
- Example: a single-byte message accepted at cycle T gives hash_valid=1 at T+1.
- hash_valid and hash_out are held until hash_ready is sampled high. in_ready returns to 1 the cycle after that.
- hash_out is the live register h; it is meaningful only while hash_valid=1.
- The multiply is single-cycle and combinational from h. There is no pipelining inside the multiplier.

## Configuration
- FNV_STREAM_MODE_EN
  - Defined:
    - Adds the 1-bit input port `mode` after in_nbytes.
    - `mode` is sampled on the first accepted beat of each message and held until DONE exits.
    - mode=0: FNV-1a (xor, then multiply).
    - mode=1: FNV-1 (h = (h*PRIME) ^ b).
  - Undefined: the port is absent and the block is FNV-1a only.

## Test plan
- HASH_WIDTH=32, IN_BYTES=1, single byte 0x61 with in_last=1:
  - Digest 0xE40C292C.
  - hash_valid rises one cycle after acceptance.
- HASH_WIDTH=32, IN_BYTES=4, "foobar" sent as beat 0x626F6F66 then in_last beat 0x????7261 with in_nbytes=2:
  - Digest 0xBF9CF968.
  - in_ready is low for 3 cycles after the first beat and for 1 cycle after the second.
- HASH_WIDTH=64, IN_BYTES=2, zero-length message (in_last=1, in_nbytes=0) -> digest 0xCBF29CE484222325.
- HASH_WIDTH=64, IN_BYTES=1, "foobar" with hash_ready held low for 5 cycles:
  - Digest 0x85944171F73967E8, held stable throughout.
  - in_ready stays 0 until one cycle after hash_ready.
- reset_n asserted low for one cycle mid-message, then "a" is sent:
  - hash_valid=0 and in_ready=1 right after the reset cycle.
  - Digest 0xE40C292C, with no contamination from the discarded message.
- With FNV_STREAM_MODE_EN, HASH_WIDTH=32, mode=1, byte 0x61 -> digest 0x050C5D7E.
